// File: rtl/velo_pkg.sv
// velo_pkg: shared constants and types for the velo capture/scanout pair.
//   - 640x480@60 timing constants and their totals
//   - framebuffer geometry (source lines, words per line, address width)
//   - vid_timing_t bundles one timing geometry so blocks can be parameterised
//     as a unit; vid_ctl_t is the per-pixel control word carried down the
//     scanout pipeline.
package velo_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525

  localparam int unsigned SRC_LINES      = 240;
  localparam int unsigned WORDS_PER_LINE = H_ACTIVE / 4;               // 160
  localparam int unsigned FB_AW          = 19;
  localparam int unsigned PIX_W          = 4;

  // Counter width: wide enough for both 800 and 525.
  localparam int unsigned CNT_W = 10;

  localparam logic [23:0] RGB_LIT = 24'hFFFFFF;
  localparam logic [23:0] RGB_OFF = 24'h000000;

  typedef logic [PIX_W-1:0] pix_word_t;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    int unsigned words_per_line;
  } vid_timing_t;

  localparam vid_timing_t VGA_640X480 = '{
    h_active: H_ACTIVE, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
    v_active: V_ACTIVE, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP,
    words_per_line: WORDS_PER_LINE
  };

  // Control bits that travel alongside the pixel data.
  typedef struct packed {
    logic de;
    logic hsync;   // active-low
    logic vsync;   // active-low
    logic fstart;
  } vid_ctl_t;

  localparam vid_ctl_t CTL_IDLE = '{de: 1'b0, hsync: 1'b1, vsync: 1'b1, fstart: 1'b0};

  function automatic int unsigned h_total(input vid_timing_t t);
    return t.h_active + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic int unsigned v_total(input vid_timing_t t);
    return t.v_active + t.v_fp + t.v_sync + t.v_bp;
  endfunction

endpackage

// File: rtl/velo_scanout_if.sv
// velo_scanout_if: framebuffer read port plus video-encoder output bundle.
//   master : scanout side (drives read strobe/address and video outputs)
//   slave  : BRAM/encoder side (returns read data one clock after fb_rd_en)
interface velo_scanout_if;
  import velo_pkg::*;

  logic             fb_rd_en;
  logic [FB_AW-1:0] fb_rd_addr;
  pix_word_t        fb_rd_data;
  logic             out_hsync;
  logic             out_vsync;
  logic             out_de;
  logic [23:0]      out_rgb;
  logic             frame_start;

  modport master (
    output fb_rd_en, fb_rd_addr,
    output out_hsync, out_vsync, out_de, out_rgb, frame_start,
    input  fb_rd_data
  );

  modport slave (
    input  fb_rd_en, fb_rd_addr,
    input  out_hsync, out_vsync, out_de, out_rgb, frame_start,
    output fb_rd_data
  );
endinterface

// File: rtl/velo_video_timing.sv
// velo_video_timing: free-running h/v raster counters and T0 region decode.
//   pix_clk, rst_n   : clock, async active-low reset (counters -> 0,0)
//   o_h_cnt/o_v_cnt  : current raster position
//   o_active         : inside the visible window
//   o_hsync/o_vsync  : active-low syncs for this position
//   o_frame_first    : position (0,0)
//   o_line_end       : last clock of a line; o_frame_end: last clock of a frame
// All outputs are combinational decodes of the counter registers.
module velo_video_timing
  import velo_pkg::*;
#(
  parameter vid_timing_t TIMING = VGA_640X480
) (
  input  logic             pix_clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] o_h_cnt,
  output logic [CNT_W-1:0] o_v_cnt,
  output logic             o_active,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_frame_first,
  output logic             o_line_end,
  output logic             o_frame_end
);

  localparam int unsigned H_TOT  = h_total(TIMING);
  localparam int unsigned V_TOT  = v_total(TIMING);
  localparam int unsigned HS_BEG = TIMING.h_active + TIMING.h_fp;
  localparam int unsigned HS_END = HS_BEG + TIMING.h_sync;
  localparam int unsigned VS_BEG = TIMING.v_active + TIMING.v_fp;
  localparam int unsigned VS_END = VS_BEG + TIMING.v_sync;

  logic [CNT_W-1:0] r_h_cnt, r_v_cnt;
  logic             w_line_end, w_frame_end;

  assign w_line_end  = (r_h_cnt == CNT_W'(H_TOT - 1));
  assign w_frame_end = w_line_end && (r_v_cnt == CNT_W'(V_TOT - 1));

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_line_end) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_frame_end ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign o_h_cnt       = r_h_cnt;
  assign o_v_cnt       = r_v_cnt;
  assign o_active      = (r_h_cnt < CNT_W'(TIMING.h_active)) &&
                         (r_v_cnt < CNT_W'(TIMING.v_active));
  assign o_hsync       = !((r_h_cnt >= CNT_W'(HS_BEG)) && (r_h_cnt < CNT_W'(HS_END)));
  assign o_vsync       = !((r_v_cnt >= CNT_W'(VS_BEG)) && (r_v_cnt < CNT_W'(VS_END)));
  assign o_frame_first = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign o_line_end    = w_line_end;
  assign o_frame_end   = w_frame_end;

endmodule

// File: rtl/velo_scanout.sv
// velo_scanout: reads the 4-bit packed mono framebuffer and produces
// line-doubled 640x480 video for the encoder.
//   pix_clk : pixel clock (only clock)
//   rst_n   : async active-low reset
//   bus     : velo_scanout_if.master -- fb_rd_en/fb_rd_addr out, fb_rd_data in
//             (1-clock BRAM latency), out_hsync/out_vsync/out_de/out_rgb/
//             frame_start out.
// Pipeline: T0 counters + fetch, T1 BRAM data/unpack, T2 output registers.
// Outputs therefore trail the raster counters by exactly 2 clocks.
module velo_scanout
  import velo_pkg::*;
#(
  parameter vid_timing_t TIMING = VGA_640X480
) (
  input  logic            pix_clk,
  input  logic            rst_n,
  velo_scanout_if.master  bus
);

  logic [CNT_W-1:0] w_h_cnt, w_v_cnt;
  logic             w_active, w_hsync, w_vsync, w_frame_first;
  logic             w_line_end, w_frame_end, w_fetch;
  vid_ctl_t         w_ctl_t0, r_ctl_t1, r_ctl_t2;
  logic             r_fetch_t1;
  pix_word_t        r_shift, w_word_t1;
  logic [FB_AW-1:0] r_line_base;
  logic [23:0]      r_rgb;

  velo_video_timing #(.TIMING(TIMING)) u_timing (
    .pix_clk       (pix_clk),
    .rst_n         (rst_n),
    .o_h_cnt       (w_h_cnt),
    .o_v_cnt       (w_v_cnt),
    .o_active      (w_active),
    .o_hsync       (w_hsync),
    .o_vsync       (w_vsync),
    .o_frame_first (w_frame_first),
    .o_line_end    (w_line_end),
    .o_frame_end   (w_frame_end)
  );

  // One read per 4-pixel word. rst_n gates the strobe so no read escapes
  // while reset is held (the counters sit at the first visible pixel).
  assign w_fetch        = rst_n & w_active & (w_h_cnt[1:0] == 2'b00);
  assign bus.fb_rd_en   = w_fetch;
  assign bus.fb_rd_addr = r_line_base + FB_AW'(w_h_cnt[CNT_W-1:2]);

  assign w_ctl_t0 = '{de: w_active, hsync: w_hsync, vsync: w_vsync, fstart: w_frame_first};

  // T1 word: fresh BRAM data on the cycle after a fetch, otherwise the
  // shifted remainder. fb_rd_data is only looked at when a read was issued,
  // so undriven/X data on idle cycles never reaches the pixel path.
  // MSB is the current pixel; the register holds the already-shifted word.
  assign w_word_t1 = r_fetch_t1 ? bus.fb_rd_data : r_shift;

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctl_t1    <= CTL_IDLE;
      r_ctl_t2    <= CTL_IDLE;
      r_fetch_t1  <= 1'b0;
      r_shift     <= '0;
      r_rgb       <= RGB_OFF;
      r_line_base <= '0;
    end else begin
      r_ctl_t1   <= w_ctl_t0;
      r_ctl_t2   <= r_ctl_t1;
      r_fetch_t1 <= w_fetch;
      r_shift    <= w_word_t1 << 1;
      r_rgb      <= (r_ctl_t1.de && w_word_t1[PIX_W-1]) ? RGB_LIT : RGB_OFF;
      // Advance the source line after every second visible output line so
      // each source line is scanned twice.
      if (w_frame_end)
        r_line_base <= '0;
      else if (w_line_end && (w_v_cnt < CNT_W'(TIMING.v_active)) && w_v_cnt[0])
        r_line_base <= r_line_base + FB_AW'(TIMING.words_per_line);
    end
  end

  assign bus.out_de      = r_ctl_t2.de;
  assign bus.out_hsync   = r_ctl_t2.hsync;
  assign bus.out_vsync   = r_ctl_t2.vsync;
  assign bus.frame_start = r_ctl_t2.fstart;
  assign bus.out_rgb     = r_rgb;

endmodule

// File: tb/tb_velo_scanout.sv
// Bench for velo_scanout: one full-size 640x480 instance plus one instance on
// a shrunken raster (16x8 visible, 32x15 total) so frame-level behaviour
// (vsync, frame period, last fetched address) fits in a short run.
module tb_velo_scanout;
  import velo_pkg::*;

  localparam vid_timing_t SMALL = '{
    h_active: 16, h_fp: 4, h_sync: 8, h_bp: 4,
    v_active: 8,  v_fp: 2, v_sync: 2, v_bp: 3,
    words_per_line: 4
  };

  logic pix_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 pix_clk = ~pix_clk;

  velo_scanout_if bus0 ();
  velo_scanout_if bus1 ();

  velo_scanout u_dut (
    .pix_clk (pix_clk),
    .rst_n   (rst_n),
    .bus     (bus0)
  );

  velo_scanout #(.TIMING(SMALL)) u_small (
    .pix_clk (pix_clk),
    .rst_n   (rst_n),
    .bus     (bus1)
  );

  int        mode     = 0;
  logic [3:0] idle_val = 4'bxxxx;
  int        n_pass   = 0;
  int        n_tot    = 0;
  int        n_bad0   = 0;
  int        n_bad1   = 0;
  int        n_xrgb   = 0;

  // BRAM contents: mode 0 = decode pattern, mode 1 = word n holds n[3:0].
  function automatic logic [3:0] bram_word(input logic [FB_AW-1:0] a);
    if (mode == 1) return a[3:0];
    if (a == 0) return 4'b1010;
    if (a == 1) return 4'b0001;
    return 4'b0000;
  endfunction

  // Synchronous-read BRAM models; idle cycles return idle_val (X by default).
  always @(posedge pix_clk) begin
    bus0.fb_rd_data <= bus0.fb_rd_en ? bram_word(bus0.fb_rd_addr) : idle_val;
    bus1.fb_rd_data <= bus1.fb_rd_en ? bram_word(bus1.fb_rd_addr) : idle_val;
  end

  always @(negedge pix_clk) begin
    if (rst_n) begin
      if (bus0.fb_rd_en && (bus0.fb_rd_addr > 19'd38399)) n_bad0++;
      if (bus1.fb_rd_en && (bus1.fb_rd_addr > 19'd15))    n_bad1++;
      if ($isunknown(bus0.out_rgb) || $isunknown(bus1.out_rgb)) n_xrgb++;
    end
  end

  task automatic step();
    @(posedge pix_clk);
    @(negedge pix_clk);
  endtask

  // After return the raster is at T0 position (0,0).
  task automatic do_reset(input int n);
    @(negedge pix_clk);
    rst_n = 1'b0;
    repeat (n) @(negedge pix_clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(negedge pix_clk);
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge pix_clk);
      n_tot++; if (bus0.out_de !== 1'b0) $display("FAIL rst_de got %0b want 0", bus0.out_de); else n_pass++;
      n_tot++; if ({bus0.out_hsync, bus0.out_vsync} !== 2'b11) $display("FAIL rst_syncs got %b want 11", {bus0.out_hsync, bus0.out_vsync}); else n_pass++;
      n_tot++; if (bus0.fb_rd_en !== 1'b0) $display("FAIL rst_rd_en got %0b want 0", bus0.fb_rd_en); else n_pass++;
    end
    n_tot++; if (bus0.out_rgb !== 24'h0) $display("FAIL rst_rgb got %h want 000000", bus0.out_rgb); else n_pass++;
    n_tot++; if (bus0.fb_rd_addr !== 19'd0) $display("FAIL rst_addr got %0d want 0", bus0.fb_rd_addr); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_tot++; if (bus0.fb_rd_en !== 1'b1) $display("FAIL rel_rd_en got %0b want 1", bus0.fb_rd_en); else n_pass++;
    step();
    n_tot++; if (bus0.frame_start !== 1'b0) $display("FAIL fs_early got %0b want 0", bus0.frame_start); else n_pass++;
    step();
    n_tot++; if (bus0.frame_start !== 1'b1) $display("FAIL fs_pulse got %0b want 1", bus0.frame_start); else n_pass++;
    n_tot++; if (bus0.out_de !== 1'b1) $display("FAIL fs_de got %0b want 1", bus0.out_de); else n_pass++;
    step();
    n_tot++; if (bus0.frame_start !== 1'b0) $display("FAIL fs_width got %0b want 0", bus0.frame_start); else n_pass++;
  endtask

  task automatic test_pixel_decode();
    logic [23:0] exp_rgb [8];
    exp_rgb = '{24'hFFFFFF, 24'h0, 24'hFFFFFF, 24'h0, 24'h0, 24'h0, 24'h0, 24'hFFFFFF};
    mode = 0;
    do_reset(3);
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      n_tot++; if (bus0.out_rgb !== exp_rgb[i]) $display("FAIL decode_px%0d got %h want %h", i, bus0.out_rgb, exp_rgb[i]); else n_pass++;
      step();
    end
  endtask

  task automatic test_line_doubling();
    int fe_err, out_err, L, h, p, d;
    int fetches [3];
    logic [FB_AW-1:0] first_a [3];
    logic [FB_AW-1:0] last_a [3];
    logic [FB_AW-1:0] ea;
    logic e_en, e_de, e_hs;
    logic [23:0] e_rgb;
    fe_err = 0; out_err = 0;
    for (int i = 0; i < 3; i++) begin fetches[i] = 0; first_a[i] = '1; last_a[i] = '1; end
    mode = 1;
    do_reset(3);
    for (int k = 0; k < 2402; k++) begin
      if (k < 2400) begin
        L = k / 800; h = k % 800;
        e_en = (h < 640) && (h % 4 == 0);
        if (bus0.fb_rd_en !== e_en) fe_err++;
        else if (e_en) begin
          ea = 19'((L / 2) * 160 + h / 4);
          if (bus0.fb_rd_addr !== ea) fe_err++;
          if (fetches[L] == 0) first_a[L] = bus0.fb_rd_addr;
          last_a[L] = bus0.fb_rd_addr;
          fetches[L]++;
        end
      end
      if (k >= 2) begin
        p = k - 2; L = p / 800; h = p % 800;
        e_de = (h < 640);
        e_hs = !((h >= 656) && (h < 752));
        e_rgb = 24'h0;
        if (e_de) begin
          d = ((L / 2) * 160 + h / 4) % 16;
          if (((d >> (3 - h % 4)) & 1) == 1) e_rgb = 24'hFFFFFF;
        end
        if (bus0.out_de !== e_de || bus0.out_hsync !== e_hs || bus0.out_vsync !== 1'b1 ||
            bus0.out_rgb !== e_rgb) out_err++;
      end
      step();
    end
    n_tot++; if (fe_err != 0) $display("FAIL dbl_fetch_errs got %0d want 0", fe_err); else n_pass++;
    n_tot++; if (out_err != 0) $display("FAIL dbl_out_errs got %0d want 0", out_err); else n_pass++;
    n_tot++; if (fetches[0] != 160) $display("FAIL dbl_line0_reads got %0d want 160", fetches[0]); else n_pass++;
    n_tot++; if (fetches[1] != 160) $display("FAIL dbl_line1_reads got %0d want 160", fetches[1]); else n_pass++;
    n_tot++; if (last_a[0] !== 19'd159) $display("FAIL dbl_line0_last got %0d want 159", last_a[0]); else n_pass++;
    n_tot++; if (first_a[1] !== 19'd0) $display("FAIL dbl_line1_first got %0d want 0", first_a[1]); else n_pass++;
    n_tot++; if (last_a[1] !== 19'd159) $display("FAIL dbl_line1_last got %0d want 159", last_a[1]); else n_pass++;
    n_tot++; if (first_a[2] !== 19'd160) $display("FAIL dbl_line2_first got %0d want 160", first_a[2]); else n_pass++;
  endtask

  task automatic test_line_timing();
    int rise, rise2, fall, hsf, hsr;
    logic pde, phs;
    rise = -1; rise2 = -1; fall = -1; hsf = -1; hsr = -1;
    do_reset(3);
    pde = 1'b0; phs = 1'b1;
    for (int t = 0; t < 1700; t++) begin
      if (bus0.out_de && !pde) begin
        if (rise < 0) rise = t; else if (rise2 < 0) rise2 = t;
      end
      if (!bus0.out_de && pde && rise >= 0 && fall < 0) fall = t;
      if (!bus0.out_hsync && phs && rise >= 0 && hsf < 0) hsf = t;
      if (bus0.out_hsync && !phs && hsf >= 0 && hsr < 0) hsr = t;
      pde = bus0.out_de; phs = bus0.out_hsync;
      step();
    end
    n_tot++; if (rise != 2) $display("FAIL tim_latency got %0d want 2", rise); else n_pass++;
    n_tot++; if (fall - rise != 640) $display("FAIL tim_de_len got %0d want 640", fall - rise); else n_pass++;
    n_tot++; if (hsf - rise != 656) $display("FAIL tim_hs_offset got %0d want 656", hsf - rise); else n_pass++;
    n_tot++; if (hsr - hsf != 96) $display("FAIL tim_hs_len got %0d want 96", hsr - hsf); else n_pass++;
    n_tot++; if (rise2 - rise != 800) $display("FAIL tim_line_period got %0d want 800", rise2 - rise); else n_pass++;
  endtask

  // Shrunken raster: 32 clocks/line, 15 lines/frame, vsync on lines 10-11,
  // 4 words per line, 4 source lines -> last address 15 on line 7, h=12.
  task automatic test_frame_timing();
    int fs1, fs2, vsf, vsr, dec, nf, lastk;
    logic pvs;
    logic [FB_AW-1:0] maxa;
    fs1 = -1; fs2 = -1; vsf = -1; vsr = -1; dec = 0; nf = 0; lastk = -1; maxa = '0;
    mode = 1;
    do_reset(3);
    pvs = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      if (bus1.frame_start) begin
        if (fs1 < 0) fs1 = k; else if (fs2 < 0) fs2 = k;
      end
      if (k >= 2 && k < 482 && bus1.out_de) dec++;
      if (!bus1.out_vsync && pvs && vsf < 0) vsf = k;
      if (bus1.out_vsync && !pvs && vsf >= 0 && vsr < 0) vsr = k;
      pvs = bus1.out_vsync;
      if (k < 480 && bus1.fb_rd_en) begin
        nf++;
        if (bus1.fb_rd_addr > maxa) maxa = bus1.fb_rd_addr;
        lastk = k;
      end
      step();
    end
    n_tot++; if (fs1 != 2) $display("FAIL frm_fs_first got %0d want 2", fs1); else n_pass++;
    n_tot++; if (fs2 - fs1 != 480) $display("FAIL frm_period got %0d want 480", fs2 - fs1); else n_pass++;
    n_tot++; if (vsf != 322) $display("FAIL frm_vs_start got %0d want 322", vsf); else n_pass++;
    n_tot++; if (vsr - vsf != 64) $display("FAIL frm_vs_len got %0d want 64", vsr - vsf); else n_pass++;
    n_tot++; if (dec != 128) $display("FAIL frm_de_count got %0d want 128", dec); else n_pass++;
    n_tot++; if (nf != 32) $display("FAIL frm_reads got %0d want 32", nf); else n_pass++;
    n_tot++; if (maxa !== 19'd15) $display("FAIL frm_max_addr got %0d want 15", maxa); else n_pass++;
    n_tot++; if (lastk != 236) $display("FAIL frm_last_read_at got %0d want 236", lastk); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    mode = 1;
    do_reset(3);
    repeat (1900) step();
    // Output now shows line 2, pixel 298: word 234 = 4'b1010, bit 1 -> lit.
    n_tot++; if (bus0.out_rgb !== 24'hFFFFFF) $display("FAIL mid_pre_rgb got %h want ffffff", bus0.out_rgb); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_tot++; if (bus0.out_de !== 1'b0) $display("FAIL mid_async_de got %0b want 0", bus0.out_de); else n_pass++;
    n_tot++; if (bus0.out_rgb !== 24'h0) $display("FAIL mid_async_rgb got %h want 000000", bus0.out_rgb); else n_pass++;
    n_tot++; if (bus0.fb_rd_en !== 1'b0) $display("FAIL mid_async_rd_en got %0b want 0", bus0.fb_rd_en); else n_pass++;
    repeat (3) @(negedge pix_clk);
    rst_n = 1'b1;
    #1;
    n_tot++; if (bus0.fb_rd_en !== 1'b1) $display("FAIL mid_restart_rd_en got %0b want 1", bus0.fb_rd_en); else n_pass++;
    n_tot++; if (bus0.fb_rd_addr !== 19'd0) $display("FAIL mid_restart_addr got %0d want 0", bus0.fb_rd_addr); else n_pass++;
    step();
    step();
    n_tot++; if (bus0.frame_start !== 1'b1) $display("FAIL mid_restart_fs got %0b want 1", bus0.frame_start); else n_pass++;
  endtask

  task automatic test_x_isolation();
    logic [23:0] exp_rgb [8];
    exp_rgb = '{24'hFFFFFF, 24'h0, 24'hFFFFFF, 24'h0, 24'h0, 24'h0, 24'h0, 24'hFFFFFF};
    n_tot++; if (n_xrgb != 0) $display("FAIL x_rgb_cycles got %0d want 0", n_xrgb); else n_pass++;
    // Idle-cycle garbage of all ones must not leak into the pixel stream.
    idle_val = 4'hF;
    mode = 0;
    do_reset(3);
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      n_tot++; if (bus0.out_rgb !== exp_rgb[i]) $display("FAIL xiso_px%0d got %h want %h", i, bus0.out_rgb, exp_rgb[i]); else n_pass++;
      step();
    end
    idle_val = 4'bxxxx;
  endtask

  task automatic test_addr_range();
    n_tot++; if (n_bad0 != 0) $display("FAIL range_full got %0d want 0", n_bad0); else n_pass++;
    n_tot++; if (n_bad1 != 0) $display("FAIL range_small got %0d want 0", n_bad1); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_pixel_decode();
    test_line_doubling();
    test_line_timing();
    test_frame_timing();
    test_reset_midframe();
    test_x_isolation();
    test_addr_range();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
